axis_pkt_framer: RTL and testbench

Write-side packet framer for `axis_async_fifo`, running in the `wr_clk` domain and sitting directly upstream of the FIFO write port. It accepts a 16-bit AXI-Stream with `tlast` framing and forwards each data beat as a FIFO write. After every packet it appends two trailer words, a word count and an XOR checksum, so the read-clock consumer can delimit and check packets. It converts `fifo_afull` into AXI-Stream backpressure through a 2-entry skid buffer and loses no data.

---
 rtl/pkt_framer_pkg.sv | 25 ++
 rtl/axis_pkt_framer_skid.sv | 76 +++++++
 rtl/axis_pkt_framer.sv | 159 +++++++++++++++
 tb/tb_axis_pkt_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_framer_pkg.sv
// pkt_framer_pkg
// Shared definitions for the write-side packet framer:
//   PKT_DATA_W  - stream / FIFO word width (the trailer format assumes 16)
//   TRL_WORDS   - trailer words appended after every packet (count, checksum)
//   LEN_MAX     - saturation value of the per-packet word counter
//   state_t     - framer FSM encoding
//   buf_entry_t - one skid buffer slot: {last, data}
package pkt_framer_pkg;

  localparam int PKT_DATA_W = 16;
  localparam int TRL_WORDS  = 2;
  localparam logic [PKT_DATA_W-1:0] LEN_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_DATA    = 2'd0,
    ST_TRL_CNT = 2'd1,
    ST_TRL_SUM = 2'd2
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [PKT_DATA_W-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/axis_pkt_framer_skid.sv
// axis_skid_buf2
// Two-entry FIFO-ordered skid buffer with a registered ready.
// Ports:
//   i_clk, i_resetn  - clock, synchronous active-low reset
//   i_push_valid     - upstream valid; a push happens when it and o_ready are high
//   i_push_data      - entry to push
//   o_ready          - registered; high when occupancy after the current edge is below DEPTH
//   i_pop            - pop the head this edge (ignored when empty)
//   o_head           - current head entry (valid when o_count != 0)
//   o_count          - current occupancy, 0..2
module axis_skid_buf2
  import pkt_framer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_push_valid,
  input  buf_entry_t i_push_data,
  output logic       o_ready,
  input  logic       i_pop,
  output buf_entry_t o_head,
  output logic [1:0] o_count
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  buf_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_ready;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push = i_push_valid & r_ready;
  assign w_pop  = i_pop & (r_count != 2'd0);

  // Simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      // Ready looks at the occupancy the buffer will have after this edge,
      // so it can never accept into a full buffer.
      r_ready <= (w_count_nxt < FULL_CNT);
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_ready = r_ready;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/axis_pkt_framer.sv
// axis_pkt_framer
// Write-side packet framer in the wr_clk domain, directly upstream of the
// async FIFO write port. Each accepted data beat becomes one FIFO write; after
// the tlast beat two trailer words follow: the packet word count (saturating
// at 0xFFFF) and the XOR of all data words.
// Ports:
//   wr_clk, resetn       - clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tready - input AXI-Stream (s_tready registered)
//   fifo_afull           - FIFO almost-full; while high no write is issued
//   wr_en, wr_data       - registered FIFO write strobe and data
//   pkt_done             - one-cycle pulse together with the checksum write
//   pkt_cnt              - packets fully framed since reset (wraps)
//   len_err              - sticky: some packet exceeded 0xFFFF words
//   o_dbg_state          - current FSM state, for observation only
//
// Handshake: a beat transfers on a rising edge where s_tvalid and s_tready are
// both high; s_tdata/s_tlast are only sampled on that edge, and the source may
// change them freely otherwise. Downstream, every edge with wr_en high is one
// FIFO write; there is no ready on that side, only fifo_afull.
module axis_pkt_framer
  import pkt_framer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              wr_clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic              fifo_afull,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              pkt_done,
  output logic [15:0]       pkt_cnt,
  output logic              len_err,
  output state_t            o_dbg_state
);

  // Skid buffer interface
  buf_entry_t w_push_entry;
  buf_entry_t w_head;
  logic [1:0] w_count;
  logic       w_ready;

  // FSM
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_pop;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_done;

  // Output and accounting registers
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_pkt_done;
  logic [15:0]       r_pkt_cnt;
  logic              r_len_err;
  logic [15:0]       r_len_cnt;
  logic [DATA_W-1:0] r_csum;

  assign w_push_entry.last = s_tlast;
  assign w_push_entry.data = s_tdata;

  axis_skid_buf2 #(
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .i_clk        (wr_clk),
    .i_resetn     (resetn),
    .i_push_valid (s_tvalid),
    .i_push_data  (w_push_entry),
    .o_ready      (w_ready),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  always_ff @(posedge wr_clk) begin
    if (!resetn) r_state <= ST_DATA;
    else         r_state <= w_state_nxt;
  end

  // Any edge with fifo_afull high is a full stall: no write, no pop, state
  // and wr_data hold. The trailer states never pop, so input keeps filling
  // the buffer until ready drops.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = r_wr_data;
    w_done      = 1'b0;
    case (r_state)
      ST_DATA: begin
        if (!fifo_afull && (w_count != 2'd0)) begin
          w_pop     = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_data = w_head.data;
          if (w_head.last) w_state_nxt = ST_TRL_CNT;
        end
      end
      ST_TRL_CNT: begin
        if (!fifo_afull) begin
          w_wr_en     = 1'b1;
          w_wr_data   = r_len_cnt;
          w_state_nxt = ST_TRL_SUM;
        end
      end
      ST_TRL_SUM: begin
        if (!fifo_afull) begin
          w_wr_en     = 1'b1;
          w_wr_data   = r_csum;
          w_done      = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      default: w_state_nxt = ST_DATA;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (!resetn) begin
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_cnt  <= 16'd0;
      r_len_err  <= 1'b0;
      r_len_cnt  <= 16'd0;
      r_csum     <= '0;
    end else begin
      r_wr_en    <= w_wr_en;
      r_wr_data  <= w_wr_data;
      r_pkt_done <= w_done;
      if (w_pop) begin
        // Counter saturates; a word beyond 0xFFFF raises the sticky error
        // but is still folded into the checksum.
        if (r_len_cnt == LEN_MAX) r_len_err <= 1'b1;
        else                      r_len_cnt <= r_len_cnt + 16'd1;
        r_csum <= r_csum ^ w_head.data;
      end
      // Pop and checksum write are in different states, never the same edge.
      if (w_done) begin
        r_len_cnt <= 16'd0;
        r_csum    <= '0;
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  assign s_tready    = w_ready;
  assign wr_en       = r_wr_en;
  assign wr_data     = r_wr_data;
  assign pkt_done    = r_pkt_done;
  assign pkt_cnt     = r_pkt_cnt;
  assign len_err     = r_len_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axis_pkt_framer.sv
`timescale 1ns/1ps
module tb_axis_pkt_framer;
  import pkt_framer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        wr_clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] s_tdata = 16'h0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        fifo_afull = 1'b0;
  logic        s_tready;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        pkt_done;
  logic [15:0] pkt_cnt;
  logic        len_err;
  state_t      dbg_state;

  always #5 wr_clk = ~wr_clk;

  axis_pkt_framer #(.DATA_W(16), .BUF_DEPTH(2)) dut (
    .wr_clk      (wr_clk),
    .resetn      (resetn),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .fifo_afull  (fifo_afull),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .pkt_done    (pkt_done),
    .pkt_cnt     (pkt_cnt),
    .len_err     (len_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int stall_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- model: expected FIFO write stream ----------------
  // Entry: {ovf, is_sum, data}. Built from accepted beats: the data words in
  // order, then on tlast the saturated count and the XOR checksum.
  logic [17:0] exp_q[$];
  logic [15:0] wr_log[$];
  int          wr_cyc[$];
  int          m_len = 0;
  logic [15:0] m_csum = 16'h0;
  logic [15:0] m_pkt_cnt = 16'h0;
  logic        m_len_err = 1'b0;
  logic [15:0] m_last_wr = 16'h0;
  logic        rst_at_edge = 1'b1;
  logic        afull_at_edge = 1'b0;

  always @(posedge wr_clk) begin
    cycle++;
    rst_at_edge   = !resetn;
    afull_at_edge = fifo_afull;
    if (!resetn) begin
      exp_q.delete();
      m_len  = 0;
      m_csum = 16'h0;
    end else if (s_tvalid && s_tready) begin
      m_len++;
      m_csum ^= s_tdata;
      exp_q.push_back({(m_len > 65535), 1'b0, s_tdata});
      if (s_tlast) begin
        exp_q.push_back({1'b0, 1'b0, (m_len > 65535) ? 16'hFFFF : 16'(m_len)});
        exp_q.push_back({1'b0, 1'b1, m_csum});
        m_len  = 0;
        m_csum = 16'h0;
      end
    end
  end

  // ---------------- compare process (every cycle) ----------------
  always @(negedge wr_clk) begin
    logic [17:0] e;
    if (rst_at_edge) begin
      m_pkt_cnt = 16'h0;
      m_len_err = 1'b0;
      m_last_wr = 16'h0;
      chk("rst_tready",   {31'b0, s_tready}, 32'd0);
      chk("rst_wr_en",    {31'b0, wr_en},    32'd0);
      chk("rst_wr_data",  {16'b0, wr_data},  32'd0);
      chk("rst_pkt_done", {31'b0, pkt_done}, 32'd0);
      chk("rst_pkt_cnt",  {16'b0, pkt_cnt},  32'd0);
      chk("rst_len_err",  {31'b0, len_err},  32'd0);
    end else begin
      if (wr_en === 1'b1) begin
        chk("wr_during_afull", {31'b0, afull_at_edge}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write actual=%h expected=none (cycle %0d)", wr_data, cycle);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", {16'b0, wr_data}, {16'b0, e[15:0]});
          if (e[17]) m_len_err = 1'b1;
          if (e[16]) m_pkt_cnt = m_pkt_cnt + 16'd1;
          chk("pkt_done", {31'b0, pkt_done}, {31'b0, e[16]});
          m_last_wr = e[15:0];
        end
        wr_log.push_back(wr_data);
        wr_cyc.push_back(cycle);
      end else begin
        chk("wr_en_low",    {31'b0, wr_en},    32'd0);
        chk("pkt_done_low", {31'b0, pkt_done}, 32'd0);
        chk("wr_data_hold", {16'b0, wr_data},  {16'b0, m_last_wr});
      end
      chk("pkt_cnt", {16'b0, pkt_cnt}, {16'b0, m_pkt_cnt});
      chk("len_err", {31'b0, len_err}, {31'b0, m_len_err});
    end
  end

  // ---------------- driver tasks ----------------
  // All driver activity happens 1 ns after a rising edge.
  task automatic send_word(input logic [15:0] d, input logic last);
    int n;
    logic was_ready;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    forever begin
      was_ready = s_tready;
      @(posedge wr_clk);
      #1;
      if (was_ready) break;
      n++;
      stall_cycles++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=stalled expected=accept data=%h", d);
        break;
      end
    end
  endtask

  task automatic go_idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    go_idle();
    fifo_afull = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    chk("tready_in_reset", {31'b0, s_tready}, 32'd0);
    resetn = 1'b1;
    @(posedge wr_clk);
    #1;
    chk("tready_after_reset", {31'b0, s_tready}, 32'd1);
    wr_log.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_en === 1'b1) && n < budget) begin
      @(posedge wr_clk);
      #1;
      n++;
    end
    @(posedge wr_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 words pending", exp_q.size());
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [15:0] exp);
    if (idx < wr_log.size()) chk(name, {16'b0, wr_log[idx]}, {16'b0, exp});
    else begin
      checks++;
      errors++;
      $display("FAIL %s actual=missing expected=%h", name, exp);
    end
  endtask

  // ---------------- directed tests ----------------
  logic [15:0] exp3 [0:4];
  logic [15:0] exp_af [0:7];
  logic [15:0] exp_b2b [0:11];
  int acc_cyc;
  int waited;

  initial begin
    exp3    = '{16'h1111, 16'h2222, 16'h3333, 16'h0003, 16'h0000};
    exp_af  = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06,
                16'h0006, 16'h0007};
    exp_b2b = '{16'h1000, 16'h2000, 16'h4000, 16'h8000, 16'h0004, 16'hF000,
                16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0004, 16'h000F};

    // 3-word packet
    do_reset();
    send_word(16'h1111, 1'b0);
    acc_cyc = cycle;
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b1);
    go_idle();
    wait_drain(50);
    chk("t1_nwrites", wr_log.size(), 5);
    for (int i = 0; i < 5; i++) chk_log("t1_word", i, exp3[i]);
    if (wr_cyc.size() == 5) begin
      chk("t1_latency", wr_cyc[0], acc_cyc + 1);
      for (int i = 1; i < 5; i++) chk("t1_back_to_back", wr_cyc[i], wr_cyc[0] + i);
    end
    chk("t1_pkt_cnt", {16'b0, pkt_cnt}, 32'd1);
    chk("t1_state_idle", {30'b0, dbg_state}, {30'b0, ST_DATA});

    // 1-word packet (tlast on the first beat)
    wr_log.delete();
    wr_cyc.delete();
    send_word(16'hABCD, 1'b1);
    go_idle();
    wait_drain(50);
    chk("t2_nwrites", wr_log.size(), 1 + TRL_WORDS);
    chk_log("t2_w0", 0, 16'hABCD);
    chk_log("t2_w1", 1, 16'h0001);
    chk_log("t2_w2", 2, 16'hABCD);
    chk("t2_pkt_cnt", {16'b0, pkt_cnt}, 32'd2);

    // afull stall mid-packet
    do_reset();
    fork
      begin
        for (int i = 1; i <= 6; i++) send_word(16'h0A00 + 16'(i), (i == 6));
        go_idle();
      end
      begin
        waited = 0;
        while (wr_log.size() < 2 && waited < 50) begin
          @(posedge wr_clk);
          #1;
          waited++;
        end
        fifo_afull = 1'b1;
        repeat (10) @(posedge wr_clk);
        #1;
        chk("t3_tready_low_full", {31'b0, s_tready}, 32'd0);
        chk("t3_no_wr_in_stall", {31'b0, wr_en}, 32'd0);
        fifo_afull = 1'b0;
      end
    join
    wait_drain(100);
    chk("t3_nwrites", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) chk_log("t3_word", i, exp_af[i]);

    // Back-to-back packets, tvalid held high
    do_reset();
    stall_cycles = 0;
    send_word(16'h1000, 1'b0);
    send_word(16'h2000, 1'b0);
    send_word(16'h4000, 1'b0);
    send_word(16'h8000, 1'b1);
    send_word(16'h0001, 1'b0);
    send_word(16'h0002, 1'b0);
    send_word(16'h0004, 1'b0);
    send_word(16'h0008, 1'b1);
    go_idle();
    wait_drain(100);
    chk("t4_nwrites", wr_log.size(), 12);
    for (int i = 0; i < 12; i++) chk_log("t4_word", i, exp_b2b[i]);
    chk("t4_tready_dipped", {31'b0, (stall_cycles > 0)}, 32'd1);
    chk("t4_pkt_cnt", {16'b0, pkt_cnt}, 32'd2);

    // Length overflow: 65537 words of 0x0001
    wr_log.delete();
    wr_cyc.delete();
    for (int i = 0; i < 65537; i++) send_word(16'h0001, (i == 65536));
    go_idle();
    wait_drain(100);
    chk("t6_nwrites", wr_log.size(), 65539);
    chk_log("t6_cnt_trailer", 65537, 16'hFFFF);
    chk_log("t6_sum_trailer", 65538, 16'h0001);
    chk("t6_len_err", {31'b0, len_err}, 32'd1);
    chk("t6_pkt_cnt", {16'b0, pkt_cnt}, 32'd3);
    wr_log.delete();
    wr_cyc.delete();
    send_word(16'h0042, 1'b1);
    go_idle();
    wait_drain(50);
    chk_log("t6_next_w0", 0, 16'h0042);
    chk_log("t6_next_cnt", 1, 16'h0001);
    chk_log("t6_next_sum", 2, 16'h0042);
    chk("t6_len_err_sticky", {31'b0, len_err}, 32'd1);

    // Reset mid-packet (pkt_cnt=4, len_err=1 beforehand)
    send_word(16'h0C01, 1'b0);
    send_word(16'h0C02, 1'b0);
    go_idle();
    resetn = 1'b0;
    @(posedge wr_clk);
    #1;
    resetn = 1'b1;
    chk("t5_pkt_cnt_cleared", {16'b0, pkt_cnt}, 32'd0);
    chk("t5_len_err_cleared", {31'b0, len_err}, 32'd0);
    chk("t5_wr_en_cleared",   {31'b0, wr_en},   32'd0);
    chk("t5_wr_data_cleared", {16'b0, wr_data}, 32'd0);
    @(posedge wr_clk);
    #1;
    wr_log.delete();
    wr_cyc.delete();
    send_word(16'h0005, 1'b1);
    go_idle();
    wait_drain(50);
    chk("t5_nwrites", wr_log.size(), 3);
    chk_log("t5_w0", 0, 16'h0005);
    chk_log("t5_w1", 1, 16'h0001);
    chk_log("t5_w2", 2, 16'h0005);
    chk("t5_pkt_cnt", {16'b0, pkt_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
